step_phase_sequencer: RTL and testbench

Per-instruction phase controller for the multi-cycle pipeline CPU. It turns each rising edge of the slow step clock into an ordered sequence of strobes on the fast clk: register-file write, data-memory access, register-file read, then instruction fetch. It also arbitrates the single shared memory port between data access and instruction fetch using a ready handshake.

---
 rtl/step_seq_pkg.sv | 20 ++
 rtl/step_phase_sequencer_phase_timer.sv | 26 ++
 rtl/step_phase_sequencer.sv | 136 +++++++++++++
 tb/tb_step_phase_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// Shared constants for step_phase_sequencer: FSM state codes, memory-port owner
// select values and a small state-classification helper.
package step_seq_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WB   = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_IF   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic MEM_SEL_IF   = 1'b0;
  localparam logic MEM_SEL_DATA = 1'b1;

  // True in the two phases that own the shared memory port and wait on mem_ready.
  function automatic logic is_access(input logic [2:0] s);
    return (s == S_MEM) || (s == S_IF);
  endfunction

endpackage

// File: rtl/step_phase_sequencer_phase_timer.sv
// phase_timer: up-counter cleared on every state entry, saturating at all-ones,
// with a flag for the final cycle of a phase (count == limit-1).
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // Saturate rather than wrap so a long memory wait never re-hits the last-cycle match.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == (limit - 1'b1));

endmodule

// File: rtl/step_phase_sequencer.sv
// Per-instruction phase controller: WB -> [MEM] -> RD -> IF -> DONE per step edge.
// Optional memory-access timeout is enabled by defining STEP_TIMEOUT_EN.
module step_phase_sequencer
  import step_seq_pkg::*;
#(
  parameter int WB_DLY  = 5,
  parameter int RD_DLY  = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       wb_en,
  input  logic       mem_req,
  input  logic       mem_we,
  input  logic       mem_ready,
  output logic       rf_we_stb,
  output logic       rf_rd_stb,
  output logic       mem_en,
  output logic       mem_sel,
  output logic       mem_wr,
  output logic       if_latch,
  output logic       done,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] WB_LIM = CNT_W'(WB_DLY);
  localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(RD_DLY);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  logic [2:0]       state, state_nx;
  logic             step_q, step_edge, start;
  logic             wb_en_l, mem_req_l, mem_we_l;
  logic [CNT_W-1:0] limit;
  logic             last, clr, tmo, access_ok;

  assign step_edge = step & ~step_q;
  assign start     = step_edge & (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign phase     = state;
  assign clr       = (state_nx != state);
  assign access_ok = mem_ready | tmo;

  // One timer serves WB/RD durations and the memory wait bound.
  always_comb begin
    limit = TO_LIM;
    if (state == S_WB) limit = WB_LIM;
    else if (state == S_RD) limit = RD_LIM;
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .limit (limit),
    .last  (last)
  );

`ifdef STEP_TIMEOUT_EN
  assign tmo = last & ~mem_ready & is_access(state);

  always_ff @(posedge clk) begin
    if (rst) timeout_err <= 1'b0;
    else if (tmo) timeout_err <= 1'b1;
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_WB;
      S_WB:   if (last) state_nx = mem_req_l ? S_MEM : S_RD;
      S_MEM:  if (access_ok) state_nx = S_RD;
      S_RD:   if (last) state_nx = S_IF;
      S_IF:   if (access_ok) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step_q    <= 1'b1;
      wb_en_l   <= 1'b0;
      mem_req_l <= 1'b0;
      mem_we_l  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state  <= state_nx;
      step_q <= step;
      if (start) begin
        wb_en_l   <= wb_en;
        mem_req_l <= mem_req;
        mem_we_l  <= mem_we;
      end
      if (step_edge && busy) overrun <= 1'b1;
    end
  end

  // Decoded from registered state; forced quiet during the reset cycle itself.
  always_comb begin
    rf_we_stb = 1'b0;
    rf_rd_stb = 1'b0;
    mem_en    = 1'b0;
    mem_sel   = MEM_SEL_IF;
    mem_wr    = 1'b0;
    if_latch  = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      case (state)
        S_WB:  rf_we_stb = last & wb_en_l;
        S_MEM: begin
          mem_en  = 1'b1;
          mem_sel = MEM_SEL_DATA;
          mem_wr  = mem_we_l;
        end
        S_RD:  rf_rd_stb = last;
        S_IF: begin
          mem_en   = 1'b1;
          if_latch = mem_ready;
        end
        S_DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_step_phase_sequencer.sv
// Scoreboard bench for step_phase_sequencer: a timeline model predicts every
// non-idle output cycle; a negedge monitor pops and compares what the DUT shows.
module tb_step_phase_sequencer;

  localparam int WB_DLY  = 5;
  localparam int RD_DLY  = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 6;
`ifdef STEP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, step, wb_en, mem_req, mem_we, mem_ready;
  logic       rf_we_stb, rf_rd_stb, mem_en, mem_sel, mem_wr, if_latch, done;
  logic       busy, overrun, timeout_err;
  logic [2:0] phase;

  typedef struct {
    int         cyc;
    logic [6:0] outs;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   exp_ovr = 1'b0;
  bit   exp_to = 1'b0;

  step_phase_sequencer #(
    .WB_DLY(WB_DLY), .RD_DLY(RD_DLY), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .wb_en(wb_en), .mem_req(mem_req),
    .mem_we(mem_we), .mem_ready(mem_ready), .rf_we_stb(rf_we_stb),
    .rf_rd_stb(rf_rd_stb), .mem_en(mem_en), .mem_sel(mem_sel), .mem_wr(mem_wr),
    .if_latch(if_latch), .done(done), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .phase(phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output vector order: {rf_we, rf_rd, mem_en, mem_sel, mem_wr, if_latch, done}.
  always @(negedge clk) begin
    logic [6:0] o;
    exp_t       e;
    o = {rf_we_stb, rf_rd_stb, mem_en, mem_sel, mem_wr, if_latch, done};
    if (o != 7'd0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output cyc=%0d got=%b expected=none", cyc, o);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.outs != o) begin
          errors++;
          $display("[TB] FAIL strobe_sequence got cyc=%0d outs=%b expected cyc=%0d outs=%b",
                   cyc, o, e.cyc, e.outs);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // One instruction: build the expected timeline, then drive it cycle by cycle.
  task automatic applyStimulus(input bit wb, input bit req, input bit we, input int wm,
                               input int wi, input bit dbl, input int rst_at);
    logic [6:0] ev [0:127];
    bit         frc [0:127];
    bit         val [0:127];
    int         n, m0, mlen, r0, i0, ilen, d, last_t;
    bit         mto, ito;
    exp_t       e;
    for (int t = 0; t < 128; t++) begin
      ev[t] = 7'd0; frc[t] = 1'b0; val[t] = 1'b0;
    end
    if (wb) ev[WB_DLY] |= 7'b1000000;
    m0 = WB_DLY + 1;
    r0 = m0;
    mto = 1'b0;
    if (req) begin
      mto  = TO_EN && (wm >= TIMEOUT);
      mlen = mto ? TIMEOUT : wm + 1;
      for (int t = m0; t < m0 + mlen; t++) begin
        ev[t] |= 7'b0011000 | {4'b0000, we, 2'b00};
        frc[t] = 1'b1;
      end
      if (!mto) val[m0 + mlen - 1] = 1'b1;
      r0 = m0 + mlen;
    end
    ev[r0 + RD_DLY - 1] |= 7'b0100000;
    i0   = r0 + RD_DLY;
    ito  = TO_EN && (wi >= TIMEOUT);
    ilen = ito ? TIMEOUT : wi + 1;
    for (int t = i0; t < i0 + ilen; t++) begin
      ev[t] |= 7'b0010000;
      frc[t] = 1'b1;
    end
    if (!ito) begin
      val[i0 + ilen - 1] = 1'b1;
      ev[i0 + ilen - 1] |= 7'b0000010;
    end
    d = i0 + ilen;
    ev[d] |= 7'b0000001;
    if (mto || ito) exp_to = 1'b1;
    if (dbl) exp_ovr = 1'b1;
    last_t = (rst_at > 0) ? rst_at + 4 : d + 1;

    @(posedge clk); #1;
    n = cyc;
    for (int t = 1; t <= d; t++) begin
      if (ev[t] != 7'd0 && (rst_at == 0 || t < rst_at)) begin
        e.cyc = n + t; e.outs = ev[t];
        sb.push_back(e);
      end
    end
    step = 1'b1; wb_en = wb; mem_req = req; mem_we = we;
    mem_ready = 1'($urandom);
    for (int t = 1; t <= last_t; t++) begin
      @(posedge clk); #1;
      step      = (dbl && t == 3) || (rst_at > 0 && t >= rst_at);
      rst       = (rst_at > 0 && t == rst_at);
      wb_en     = 1'($urandom);
      mem_req   = 1'($urandom);
      mem_we    = 1'($urandom);
      mem_ready = frc[t] ? val[t] : 1'($urandom);
      if (t == 1) begin
        checkOutput("busy_in_wb", 32'(busy), 32'd1);
        checkOutput("phase_wb", 32'(phase), 32'd1);
      end
      if (rst_at == 0 && t == d + 1) begin
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("overrun", 32'(overrun), 32'(exp_ovr));
        checkOutput("timeout_err", 32'(timeout_err), 32'(exp_to));
      end
      if (rst_at > 0 && t == rst_at + 1) begin
        exp_ovr = 1'b0; exp_to = 1'b0;
        checkOutput("phase_after_rst", 32'(phase), 32'd0);
        checkOutput("busy_after_rst", 32'(busy), 32'd0);
        checkOutput("overrun_after_rst", 32'(overrun), 32'd0);
        checkOutput("timeout_after_rst", 32'(timeout_err), 32'd0);
      end
    end
    step = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step = 1'b1; wb_en = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_phase", 32'(phase), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_timeout", 32'(timeout_err), 32'd0);
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    checkOutput("no_start_step_high_at_release", 32'(busy), 32'd0);
    step = 1'b0;
    repeat (2) @(posedge clk); #1;

    $display("[TB] directed sequences");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 6);
    repeat (2) @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);

    $display("[TB] randomized sequences");
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b0, 0);
      repeat (int'($urandom_range(1, 3))) @(posedge clk);
      #1;
    end

`ifdef STEP_TIMEOUT_EN
    $display("[TB] memory timeout sequence");
    applyStimulus(1'b1, 1'b1, 1'b1, TIMEOUT + 2, TIMEOUT + 2, 1'b0, 0);
`endif

    repeat (3) @(posedge clk); #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
